// File: rtl/conv2d_engine.sv
// conv2d_engine: sequences pixel/kernel reads over all input channels,
// accumulates signed products and emits one result per output pixel.
// Ports: clk, rst (sync, active-high), start, relu_en, *_base_addr,
// in_pix/kernel_weight (read data), addrA/addrB/rd_en (read side),
// out_pix/result_addr/out_valid/out_ready (result port), busy, completed.
module conv2d_engine #(
  parameter int IMG_W  = 48,
  parameter int IMG_H  = 48,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int IN_CH  = 1,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic [ADDR_W-1:0]        pix_base_addr,
  input  logic [ADDR_W-1:0]        kernel_base_addr,
  input  logic [ADDR_W-1:0]        result_base_addr,
  input  logic signed [DATA_W-1:0] in_pix,
  input  logic signed [DATA_W-1:0] kernel_weight,
  output logic [ADDR_W-1:0]        addrA,
  output logic [ADDR_W-1:0]        addrB,
  output logic                     rd_en,
  output logic signed [ACC_W-1:0]  out_pix,
  output logic [ADDR_W-1:0]        result_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     completed
);

  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int CW    = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] KM1  = CW'(K - 1);
  localparam logic [CW-1:0] CM1  = CW'(IN_CH - 1);
  localparam logic [CW-1:0] OWM1 = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OHM1 = CW'(OUT_H - 1);

  localparam logic [ADDR_W-1:0] A_PLANE = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] A_IMGW  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] A_KK    = ADDR_W'(K * K);
  localparam logic [ADDR_W-1:0] A_K     = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] A_S     = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] A_OW    = ADDR_W'(OUT_W);

  logic [2:0]              r_state;
  logic [CW-1:0]           r_kx, r_ky, r_c, r_ox, r_oy;
  logic [ADDR_W-1:0]       r_pbase, r_kbase, r_rbase;
  logic                    r_relu;
  logic                    r_vld, r_first;
  logic signed [ACC_W-1:0] r_acc;

  logic                    w_tap_last;
  logic [ADDR_W-1:0]       w_row, w_col;
  logic signed [2*DATA_W-1:0] w_pa, w_pb, w_prod;

  assign w_tap_last = (r_kx == KM1) && (r_ky == KM1) && (r_c == CM1);

  assign w_row = ADDR_W'(r_oy) * A_S + ADDR_W'(r_ky);
  assign w_col = ADDR_W'(r_ox) * A_S + ADDR_W'(r_kx);

  assign addrA = r_pbase + ADDR_W'(r_c) * A_PLANE + w_row * A_IMGW + w_col;
  assign addrB = r_kbase + ADDR_W'(r_c) * A_KK + ADDR_W'(r_ky) * A_K
               + ADDR_W'(r_kx);
  assign result_addr = r_rbase + ADDR_W'(r_oy) * A_OW + ADDR_W'(r_ox);

  // Full-width product is exact in 2*DATA_W bits.
  assign w_pa   = (2*DATA_W)'(in_pix);
  assign w_pb   = (2*DATA_W)'(kernel_weight);
  assign w_prod = w_pa * w_pb;

  assign rd_en     = (r_state == S_FETCH);
  assign out_valid = (r_state == S_WRITE);
  assign busy      = (r_state == S_FETCH) || (r_state == S_DRAIN)
                  || (r_state == S_WRITE);
  assign completed = (r_state == S_DONE);
  assign out_pix   = (r_relu && r_acc[ACC_W-1]) ? '0 : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kx    <= '0;
      r_ky    <= '0;
      r_c     <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_pbase <= '0;
      r_kbase <= '0;
      r_rbase <= '0;
      r_relu  <= 1'b0;
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_acc   <= '0;
    end else begin
      // Read data lags the address by one cycle.
      r_vld   <= (r_state == S_FETCH);
      r_first <= (r_state == S_FETCH) && (r_kx == '0)
              && (r_ky == '0) && (r_c == '0);
      if (r_vld)
        r_acc <= (r_first ? '0 : r_acc) + ACC_W'(w_prod);

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pbase <= pix_base_addr;
            r_kbase <= kernel_base_addr;
            r_rbase <= result_base_addr;
            r_relu  <= relu_en;
            r_kx    <= '0;
            r_ky    <= '0;
            r_c     <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_kx == KM1) begin
            r_kx <= '0;
            if (r_ky == KM1) begin
              r_ky <= '0;
              r_c  <= (r_c == CM1) ? '0 : r_c + 1'b1;
            end else begin
              r_ky <= r_ky + 1'b1;
            end
          end else begin
            r_kx <= r_kx + 1'b1;
          end
          if (w_tap_last)
            r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_WRITE;
        S_WRITE: begin
          if (out_ready) begin
            if (r_ox == OWM1) begin
              r_ox <= '0;
              if (r_oy == OHM1) begin
                r_oy    <= '0;
                r_state <= S_DONE;
              end else begin
                r_oy    <= r_oy + 1'b1;
                r_state <= S_FETCH;
              end
            end else begin
              r_ox    <= r_ox + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_engine.sv
// tb_conv2d_engine: directed checks of conv2d_engine over three
// configurations (4x4/1ch, 5x5 stride 2, 4x4/2ch) with a read-memory model.
module tb_conv2d_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]        st  = '0;
  logic [2:0]        rdy = '0;
  logic [2:0]        rd, vld, bsy, cmp;
  logic              relu = 1'b0;
  logic [13:0]       pbase = '0, kbase = '0, rbase = '0;
  logic signed [15:0] pix [3];
  logic signed [15:0] wt  [3];
  logic [13:0]       aA [3];
  logic [13:0]       aB [3];
  logic [13:0]       ra [3];
  logic signed [31:0] op [3];

  int mode = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  conv2d_engine #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .IN_CH(1))
  u_a (
    .clk(clk), .rst(rst), .start(st[0]), .relu_en(relu),
    .pix_base_addr(pbase), .kernel_base_addr(kbase),
    .result_base_addr(rbase), .in_pix(pix[0]), .kernel_weight(wt[0]),
    .addrA(aA[0]), .addrB(aB[0]), .rd_en(rd[0]), .out_pix(op[0]),
    .result_addr(ra[0]), .out_valid(vld[0]), .out_ready(rdy[0]),
    .busy(bsy[0]), .completed(cmp[0])
  );

  conv2d_engine #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .IN_CH(1))
  u_b (
    .clk(clk), .rst(rst), .start(st[1]), .relu_en(relu),
    .pix_base_addr(pbase), .kernel_base_addr(kbase),
    .result_base_addr(rbase), .in_pix(pix[1]), .kernel_weight(wt[1]),
    .addrA(aA[1]), .addrB(aB[1]), .rd_en(rd[1]), .out_pix(op[1]),
    .result_addr(ra[1]), .out_valid(vld[1]), .out_ready(rdy[1]),
    .busy(bsy[1]), .completed(cmp[1])
  );

  conv2d_engine #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .IN_CH(2))
  u_c (
    .clk(clk), .rst(rst), .start(st[2]), .relu_en(relu),
    .pix_base_addr(pbase), .kernel_base_addr(kbase),
    .result_base_addr(rbase), .in_pix(pix[2]), .kernel_weight(wt[2]),
    .addrA(aA[2]), .addrB(aB[2]), .rd_en(rd[2]), .out_pix(op[2]),
    .result_addr(ra[2]), .out_valid(vld[2]), .out_ready(rdy[2]),
    .busy(bsy[2]), .completed(cmp[2])
  );

  function automatic logic [15:0] pixval(input logic [13:0] a);
    logic [13:0] off;
    off = a - pbase;
    case (mode)
      0:       return 16'd1;
      1:       return 16'(off);
      2:       return (off < 14'd16) ? 16'd2 : 16'hFFFD;
      default: return 16'h8000;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rd[i]) begin
        pix[i] <= pixval(aA[i]);
        wt[i]  <= (mode == 3) ? 16'sh8000 : 16'sd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int w, output int ts);
    @(negedge clk);
    st[w] = 1'b1;
    ts = cyc;
    @(negedge clk);
    st[w] = 1'b0;
  endtask

  task automatic wait_valid(input int w, output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vld[w] && n < 200);
    if (!vld[w]) begin
      checks++;
      errors++;
      $error("FAIL valid_timeout unit=%0d observed=0 expected=1", w);
    end
    at = cyc;
  endtask

  task automatic wait_done(input int w, output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmp[w] && n < 200);
    if (!cmp[w]) begin
      checks++;
      errors++;
      $error("FAIL done_timeout unit=%0d observed=0 expected=1", w);
    end
    at = cyc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addrA"}, 32'(aA[0]), 32'd0);
    chk({tag, "_addrB"}, 32'(aB[0]), 32'd0);
    chk({tag, "_pix"},   op[0], 32'd0);
    chk({tag, "_raddr"}, 32'(ra[0]), 32'd0);
    chk({tag, "_ctl"},   32'({rd[0], vld[0], bsy[0], cmp[0]}), 32'd0);
  endtask

  // Run the 4x4 unit with out_ready high; check all four results,
  // their spacing and the completion timing.
  task automatic run_a(input string tag, input logic [31:0] exp_pix,
                       input int ts);
    int at, prev;
    prev = 0;
    for (int p = 0; p < 4; p++) begin
      wait_valid(0, at);
      chk({tag, "_pix"}, op[0], exp_pix);
      chk({tag, "_raddr"}, 32'(ra[0]), 32'(rbase + 14'(p)));
      if (p == 0) chk({tag, "_lat0"}, 32'(at - ts), 32'd11);
      else        chk({tag, "_gap"}, 32'(at - prev), 32'd11);
      prev = at;
    end
    wait_done(0, at);
    chk({tag, "_done_t"}, 32'(at - ts), 32'd45);
    chk({tag, "_busy_dn"}, 32'(bsy[0]), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(cmp[0]), 32'd0);
  endtask

  logic [31:0] exp_b [4];
  int ts, at;

  initial begin
    exp_b[0] = 32'd54;
    exp_b[1] = 32'd72;
    exp_b[2] = 32'd144;
    exp_b[3] = 32'd162;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Basic: all ones, 9 per result.
    mode = 0; pbase = 14'd0; kbase = 14'h200; rbase = 14'h300;
    rdy = 3'b111;
    go(0, ts);
    chk("first_rd", 32'(rd[0]), 32'd1);
    chk("first_addrA", 32'(aA[0]), 32'd0);
    chk("first_addrB", 32'(aB[0]), 32'h200);
    chk("first_busy", 32'(bsy[0]), 32'd1);
    run_a("basic", 32'd9, ts);

    // Stride 2 on 5x5, pixel value = offset from base.
    mode = 1; pbase = 14'd100; rbase = 14'h040;
    go(1, ts);
    for (int p = 0; p < 4; p++) begin
      wait_valid(1, at);
      chk("stride_pix", op[1], exp_b[p]);
      chk("stride_raddr", 32'(ra[1]), 32'(14'h040 + 14'(p)));
      if (p == 0) begin
        @(negedge clk);
        chk("stride_p1_addrA", 32'(aA[1]), 32'd102);
        chk("stride_p1_rd", 32'(rd[1]), 32'd1);
      end
    end
    wait_done(1, at);
    chk("stride_done_t", 32'(at - ts), 32'd45);

    // Two channels: 9*2 + 9*(-3) = -9; channel 1 plane offset 16.
    mode = 2; pbase = 14'd500; rbase = 14'd0;
    go(2, ts);
    repeat (9) @(negedge clk);
    chk("ch1_addrA", 32'(aA[2]), 32'd516);
    chk("ch1_addrB", 32'(aB[2]), 32'h209);
    for (int p = 0; p < 4; p++) begin
      wait_valid(2, at);
      chk("chan_pix", op[2], 32'hFFFF_FFF7);
      if (p == 0) chk("chan_lat0", 32'(at - ts), 32'd20);
    end
    wait_done(2, at);
    relu = 1'b1;
    go(2, ts);
    relu = 1'b0;
    for (int p = 0; p < 4; p++) begin
      wait_valid(2, at);
      chk("relu_pix", op[2], 32'd0);
    end
    wait_done(2, at);

    // Extremes: 9 * 2^30 wraps to 2^30 in 32 bits.
    mode = 3; pbase = 14'd0; rbase = 14'h300;
    go(0, ts);
    run_a("wrap", 32'h4000_0000, ts);

    // Backpressure at first WRITE for 5 cycles.
    mode = 0;
    rdy[0] = 1'b0;
    go(0, ts);
    wait_valid(0, at);
    chk("bp_pix0", op[0], 32'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_pix", op[0], 32'd9);
      chk("bp_raddr", 32'(ra[0]), 32'h300);
      chk("bp_ctl", 32'({rd[0], vld[0], bsy[0]}), 32'b011);
    end
    rdy[0] = 1'b1;
    for (int p = 1; p < 4; p++) begin
      wait_valid(0, at);
      chk("bp_rest_pix", op[0], 32'd9);
      chk("bp_rest_raddr", 32'(ra[0]), 32'(14'h300 + 14'(p)));
    end
    wait_done(0, at);
    chk("bp_done_t", 32'(at - ts), 32'd50);

    // Reset during FETCH of pixel 2.
    go(0, ts);
    wait_valid(0, at);
    wait_valid(0, at);
    repeat (3) @(negedge clk);
    chk("pre_rst_rd", 32'(rd[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;

    // Fresh run with a spurious start mid-run.
    go(0, ts);
    repeat (3) @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    run_a("restart", 32'd9, ts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2d_engine.md
# conv2d_engine

Parametrised 2-D convolution engine, the successor to the single-channel convolution datapath. For each output pixel it sequences pixel and kernel addresses over all input channels, multiplies and accumulates the returned words, and writes one result per output pixel through a ready/valid result port. It adds stride, multi-channel accumulation, optional ReLU, result backpressure and a synchronous reset. It sits between the layer controller and the shared feature-map/weight block RAMs.

## Interface
- IMG_W, 48: input feature-map width in pixels
- IMG_H, 48: input feature-map height in pixels
- K, 3: square kernel size
- STRIDE, 1: horizontal and vertical stride (≥1)
- IN_CH, 1: input channels accumulated into each output pixel
- DATA_W, 16: signed pixel/weight width
- ACC_W, 32: signed accumulator/result width (≥2*DATA_W)
- ADDR_W, 14: address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- relu_en  in  1  clamps negative results to 0; sampled at start
- pix_base_addr, kernel_base_addr, result_base_addr  in  ADDR_W  base addresses; sampled at start
- in_pix, kernel_weight  in  DATA_W  signed read data, valid one cycle after the matching address
- addrA  out  ADDR_W  pixel read address
- addrB  out  ADDR_W  kernel read address
- rd_en  out  1  read strobe for addrA/addrB
- out_pix  out  ACC_W  signed result
- result_addr  out  ADDR_W  destination address of out_pix
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- busy  out  1  high from the first cycle after start until the cycle completed is asserted
- completed  out  1  one-cycle pulse after the last result is accepted

## Operation
- Derived values: OUT_W=(IMG_W-K)/STRIDE+1, OUT_H=(IMG_H-K)/STRIDE+1, T=IN_CH*K*K taps per output pixel. Output pixels are produced in row-major order (ox fastest).
- States:
  - IDLE: if start, capture inputs, clear counters, go to FETCH.
  - FETCH: issue one tap per cycle for T cycles, with counters ordered kx fastest, then ky, then c. Then go to DRAIN.
  - DRAIN: accumulate the last tap, then go to WRITE.
  - WRITE: hold out_valid until out_ready. On accept, go to FETCH for the next pixel, or to DONE after the last pixel.
  - DONE: pulse completed, then go to IDLE.
- Address arithmetic:
  - addrA = pix_base + c*IMG_W*IMG_H + (oy*STRIDE+ky)*IMG_W + ox*STRIDE + kx
  - addrB = kernel_base + c*K*K + ky*K + kx
  - result_addr = result_base + oy*OUT_W + ox
  - All sums are modulo 2^ADDR_W.
- MAC rules:
  - The product is a full 2*DATA_W signed value, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W; there is no saturation.
  - The accumulator clears when the first tap of each pixel's data returns.
  - out_pix = (relu_en && acc<0) ? 0 : acc.
- start while busy is ignored. Reset in any state returns to IDLE at the next edge and discards partial results.

## Timing
- Reset values: addrA=0, addrB=0, rd_en=0, out_pix=0, result_addr=0, out_valid=0, busy=0, completed=0.
- rd_en is high exactly during the FETCH cycles. Read data for the tap issued at cycle n is accumulated at n+1.
- With out_ready held high, each pixel costs T+2 cycles (T FETCH, 1 DRAIN, 1 WRITE).
- out_valid rises in the cycle after DRAIN.
- completed is high one cycle after the final accept. busy falls in the same cycle.
- The first addrA/addrB appear in the cycle after start is sampled.
- Backpressure: while out_valid=1 and out_ready=0, out_pix, result_addr and out_valid are stable and no reads are issued.
- Zero-latency accept: a pixel with out_ready already high completes in WRITE in one cycle.
- The last pixel with out_ready low waits indefinitely; completed fires only after acceptance.

## Test plan
- Basic case: IMG 4x4, K=3, STRIDE=1, IN_CH=1, all pixels=1, weights=1, out_ready=1 -> 4 results of 9 at result_addr base+0..3, 11 cycles apart; completed 45 cycles after start.
- Stride: IMG 5x5, K=3, STRIDE=2, pixel value = its address, weights=1 -> 4 results. The first is the sum of addresses {0,1,2,5,6,7,10,11,12} = 54. addrA of pixel 1 begins at base+2.
- Channels: IN_CH=2, ch0 all 2, ch1 all -3, weights=1 -> each result is 18-27 = -9. With relu_en=1 -> 0. addrA for ch1 is offset by IMG_W*IMG_H.
- Extremes and wrap: DATA_W=16, in_pix=-32768, weight=-32768, T=9 -> accumulator wraps modulo 2^32 to the exact 32-bit two's-complement value; no saturation.
- Backpressure: drop out_ready for 5 cycles at the first WRITE -> out_pix and result_addr are stable and rd_en=0 throughout; the sequence resumes on accept and totals are unchanged.
- Reset and start rules: assert rst during FETCH of pixel 2 -> next cycle all outputs are 0 and the state is IDLE. A new start then produces the correct full result set. A start pulse while busy is ignored.
